to_lower_stream: RTL and testbench

- Streaming ASCII case converter that maps uppercase letters to lowercase; the inverse direction of the existing to_Upper converter.
- Bytes enter on a valid/ready handshake and are converted at acceptance.
- Converted bytes are buffered in a small FIFO and presented on a valid/ready output port.
- Sits between a byte source (UART RX, text buffer) and a consumer.
- Keeps running counts of bytes accepted and bytes converted.

---
 rtl/to_lower_stream.sv | 119 +++++++++++
 tb/tb_to_lower_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower case converter with an output FIFO.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data byte
// input; out_valid/out_ready/out_data byte output from the FIFO head;
// flush discards buffered bytes; char_count/conv_count are saturating
// statistics of accepted and case-converted bytes.
module to_lower_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] conv_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_MAX = DEPTH[AW:0];

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic       full;
    logic       empty;
    logic       is_upper;
    logic [7:0] conv_data;
    logic       wr;
    logic       rd;

    assign full  = (occ == OCC_MAX);
    assign empty = (occ == '0);

    assign is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign conv_data = is_upper ? (in_data | 8'h20) : in_data;

    // rst gates in_ready directly so it is low for the whole reset
    // interval, not just from the next edge.
    assign in_ready  = !rst && !full && !flush && (state == RUN);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A read in a flush cycle is discarded along with the rest.
    assign wr = in_valid && in_ready;
    assign rd = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else if (flush) begin
            state <= FLUSH;
        end else begin
            state <= RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr) begin
            mem[wr_ptr] <= conv_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps.
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr, rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_count <= '0;
            conv_count <= '0;
        end else if (wr) begin
            if (char_count != '1) begin
                char_count <= char_count + 1'b1;
            end
            if (is_upper && (conv_count != '1)) begin
                conv_count <= conv_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_to_lower_stream.sv
// Directed testbench for to_lower_stream with immediate assertions.
// A second instance with CNT_W=3 covers counter saturation.
module tb_to_lower_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        flush;
    logic [15:0] char_count;
    logic [15:0] conv_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic        s_flush;
    logic [2:0]  s_char_count;
    logic [2:0]  s_conv_count;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers;

    logic [7:0] bnd_in  [8];
    logic [7:0] bnd_exp [8];
    logic [7:0] bp_exp  [5];

    always #5 clk = ~clk;

    to_lower_stream #(.DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .char_count (char_count),
        .conv_count (conv_count)
    );

    to_lower_stream #(.DEPTH(4), .CNT_W(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .flush      (s_flush),
        .char_count (s_char_count),
        .conv_count (s_conv_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bnd_in  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h61, 8'h7A, 8'hC1, 8'h28};
        bnd_exp = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h61, 8'h7A, 8'hC1, 8'h28};
        bp_exp  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        flush = 1'b0;
        s_in_valid = 1'b0;
        s_in_data = 8'h00;
        s_out_ready = 1'b0;
        s_flush = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_char", char_count, 0);
        chk("rst_conv", conv_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single byte
        in_valid = 1'b1;
        in_data = 8'h48;
        tick();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h68);
        chk("single_char", char_count, 1);
        chk("single_conv", conv_count, 1);
        out_ready = 1'b1;
        tick();
        chk("single_drain", out_valid, 0);
        out_ready = 1'b0;

        // Boundary values, streamed with out_ready high
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = bnd_in[i];
            tick();
            chk($sformatf("bnd_valid%0d", i), out_valid, 1);
            chk($sformatf("bnd_data%0d", i), out_data, bnd_exp[i]);
        end
        in_valid = 1'b0;
        tick();
        chk("bnd_drain", out_valid, 0);
        chk("bnd_char", char_count, 8);
        chk("bnd_conv", conv_count, 2);
        out_ready = 1'b0;

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'h41 + 8'(i);
            #1;
            chk($sformatf("bp_ready%0d", i), in_ready, 1);
            tick();
        end
        in_data = 8'h45;
        #1;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head", out_data, 8'h61);
        tick();
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_stall_head", out_data, 8'h61);
        chk("bp_stall_char", char_count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_out%0d", i), out_data, bp_exp[i]);
            tick();
            if (i == 1) in_valid = 1'b0;
        end
        chk("bp_drain", out_valid, 0);
        chk("bp_char", char_count, 5);
        chk("bp_conv", conv_count, 5);
        out_ready = 1'b0;

        // Simultaneous read and write
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h4D;
        out_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) xfers++;
            tick();
            chk($sformatf("ss_valid%0d", i), out_valid, 1);
            chk($sformatf("ss_data%0d", i), out_data, 8'h6D);
            chk($sformatf("ss_occ%0d", i), dut.occ, 1);
        end
        in_valid = 1'b0;
        if (out_valid) xfers++;
        tick();
        chk("ss_xfers", xfers, 20);
        chk("ss_drain", out_valid, 0);
        chk("ss_char", char_count, 20);
        out_ready = 1'b0;

        // Flush
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'h41 + 8'(i);
            tick();
        end
        chk("fl_pre_char", char_count, 3);
        flush = 1'b1;
        in_data = 8'h44;
        #1;
        chk("fl_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", out_valid, 0);
        chk("fl_char", char_count, 3);
        chk("fl_state_ready", in_ready, 0);
        tick();
        chk("fl_run_ready", in_ready, 1);
        chk("fl_char2", char_count, 3);
        tick();
        in_valid = 1'b0;
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_data", out_data, 8'h64);
        chk("fl_after_char", char_count, 4);

        // Saturation on the CNT_W=3 instance
        do_reset();
        s_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_in_valid = 1'b1;
            s_in_data = 8'h41 + 8'(i);
            tick();
        end
        s_in_valid = 1'b0;
        tick();
        chk("sat_char", s_char_count, 7);
        chk("sat_conv", s_conv_count, 7);

        // Mid-stream asynchronous reset
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h50;
        tick();
        in_data = 8'h51;
        tick();
        in_valid = 1'b0;
        chk("mid_valid_pre", out_valid, 1);
        chk("mid_char_pre", char_count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_char", char_count, 0);
        chk("mid_conv", conv_count, 0);
        chk("mid_data", out_data, 8'h00);
        chk("mid_s_char", s_char_count, 0);
        chk("mid_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_post_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
